uart_rx_engine: RTL and testbench
=================================

// Module: uart_rx_engine
// PURPOSE
//  Receive-side UART engine: asynchronous 8N1-style receiver with a small word FIFO and RTS flow control.
//  Samples rxd_i at mid-bit using a programmable bit duration and validates start and stop bits.
//  Delivers received words on a valid/ready interface; flags framing and overrun errors.
//  Sits between the pad-level rxd/rts pins and the UART CSR block, which reads words and error flags.
// PARAMETERS
//  DATA_W      8   data bits per frame, LSB first
//  DIV_W       16  width of bit_duration_i, in clock cycles per bit
//  FIFO_AW     2   log2 of FIFO depth (default depth 4)
// PORTS
//  clk_i         in   1        clock
//  rst_i         in   1        synchronous, active-high reset
//  rst_soft_i    in   1        soft reset; same effect as rst_i
//  rx_en_i       in   1        receiver enable
//  bit_duration_i in  DIV_W    clock cycles per bit; legal values are >= 4
//  rxd_i         in   1        serial input, asynchronous; idles high
//  rts_o         out  1        ready-to-send; 1 = peer may transmit
//  data_o        out  DATA_W   FIFO head word
//  valid_o       out  1        FIFO not empty
//  ready_i       in   1        consumer accepts data_o when valid_o && ready_i
//  frame_err_o   out  1        sticky flag: stop bit sampled low
//  overrun_o     out  1        sticky flag: word dropped because FIFO was full
//  err_clr_i     in   1        clears both sticky flags
// BEHAVIOUR
//  Reset (rst_i or rst_soft_i):
//   - All outputs read 0; the synchronizer stages are set to 1.
//   - FIFO is emptied, FSM goes to IDLE, counters clear. Reset takes effect in the next cycle, also mid-frame.
//  Input synchronizer: rxd_i passes through 2 flops to give rxs; the FSM uses only rxs.
//  Bit counter cnt: clears to 0 on every state entry and after every sampled data bit.
//  FSM:
//   - IDLE:  rx_en_i && rxs==0 -> START.
//   - START: on the cycle with cnt == (bit_duration_i>>1)-1, sample rxs.
//            rxs==0 -> DATA with bit index 0. rxs==1 -> IDLE (glitch rejected, no flag).
//   - DATA:  on the cycle with cnt == bit_duration_i-1, shift rxs in LSB-first.
//            After DATA_W bits -> STOP.
//   - STOP:  on the cycle with cnt == bit_duration_i-1, sample rxs.
//            rxs==1 -> push word, go to IDLE.
//            rxs==0 -> frame_err_o<=1, word discarded, go to BRK.
//   - BRK:   wait for rxs==1 -> IDLE. A line held low never starts a new frame.
//  rx_en_i==0 in any state:
//   - FSM goes to IDLE next cycle; a partial word is discarded.
//   - FIFO contents and error flags are kept.
//  FIFO and output handshake:
//   - Depth 2**FIFO_AW; show-ahead. data_o is the head word and is held while valid_o && !ready_i.
//   - Pop when valid_o && ready_i. Word ordering is strictly FIFO.
//   - Latency: a pushed word appears on data_o/valid_o the cycle after the stop-bit sample cycle.
//   - Push with a pop in the same cycle is always accepted, including when the FIFO is full.
//   - Push while full with no pop: word dropped, overrun_o<=1, FIFO unchanged.
//   - Pop while empty: ignored.
//   - Pointers wrap modulo depth; a separate count distinguishes full from empty.
//  rts_o: registered; equals rx_en_i && (free slots >= 2).
//   - Deasserts when one slot remains, which leaves room for a frame already in flight.
//  Error flags:
//   - Sticky; cleared by err_clr_i the next cycle.
//   - A set event in the same cycle as err_clr_i wins, so the flag stays 1.
//  bit_duration_i: sampled continuously. A change mid-frame takes effect on the next compare.
//   Values < 4 give undefined timing but must not hang the FSM.
// TESTING (bit_duration_i=16, FIFO_AW=2, rx_en_i=1 unless stated)
//  1. Drive 8N1 frame 0xA5 with ready_i=1.
//     -> valid_o=1 with data_o=0xA5 exactly 1 cycle after the stop sample; valid_o drops the next cycle.
//     -> Flags stay 0; rts_o stays 1.
//  2. Pulse rxd low for 4 cycles, then high.
//     -> No word is pushed, no flag is set, FSM is back in IDLE.
//     -> A following 0x3C frame is received correctly.
//  3. Frame 0x3C with the stop bit driven 0, then rxd held low for 200 cycles, then high.
//     -> frame_err_o=1 and no word is pushed.
//     -> No frame starts until rxd is high; err_clr_i clears the flag.
//  4. Hold ready_i=0 and send 0x01..0x05 back-to-back.
//     -> rts_o falls after the 3rd word is pushed; 0x05 is dropped and overrun_o=1.
//     -> Raising ready_i pops 0x01..0x04 in order.
//  5. Assert rst_i for 1 cycle mid-way through DATA bits of 0x5A.
//     -> Next cycle all outputs are 0 and the FIFO is empty.
//     -> A subsequent 0x99 frame is received correctly.
//  6. Drop rx_en_i for 1 cycle mid-frame while 2 words are queued.
//     -> The partial word is discarded and the 2 queued words are retained.
//     -> rts_o=0 while rx_en_i==0.

Source files
------------

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 8N1-style serial receiver with mid-bit sampling, a small
// show-ahead word FIFO, RTS flow control and sticky framing/overrun flags.
module uart_rx_engine #(
   parameter int DATA_W  = 8,
   parameter int DIV_W   = 16,
   parameter int FIFO_AW = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rst_soft_i,
   input  logic              rx_en_i,
   input  logic [DIV_W-1:0]  bit_duration_i,
   input  logic              rxd_i,
   output logic              rts_o,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              frame_err_o,
   output logic              overrun_o,
   input  logic              err_clr_i
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int IDX_W = $clog2(DATA_W + 1);
   localparam int CNT_W = FIFO_AW + 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BRK   = 3'd4
   } state_t;

   // Either reset source has the same effect.
   logic rst_s;
   assign rst_s = rst_i | rst_soft_i;

   logic sync1_r;
   logic rxs_r;

   state_t state_r;
   state_t state_s;

   logic [DIV_W-1:0]  cnt_r;
   logic [IDX_W-1:0]  bit_idx_r;
   logic [DATA_W-1:0] shift_r;

   logic [DIV_W-1:0] half_s;
   logic [DIV_W-1:0] half_m1_s;
   logic [DIV_W-1:0] full_m1_s;
   logic             half_hit_s;
   logic             full_hit_s;

   logic sample_bit_s;
   logic push_s;
   logic frame_set_s;
   logic cnt_clr_s;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r;
   logic [FIFO_AW-1:0] rd_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic [CNT_W-1:0]   count_s;
   logic               valid_r;
   logic               rts_r;
   logic               frame_err_r;
   logic               overrun_r;
   logic               pop_s;
   logic               full_s;
   logic               wr_en_s;
   logic               ovr_set_s;

   // Two-flop synchronizer for the asynchronous serial input; idles high.
   always_ff @(posedge clk_i) begin
      if (rst_s) begin
         sync1_r <= 1'b1;
         rxs_r   <= 1'b1;
      end else begin
         sync1_r <= rxd_i;
         rxs_r   <= sync1_r;
      end
   end

   // Sample thresholds; clamped so tiny bit durations cannot underflow into a long wait.
   always_comb begin
      half_s     = bit_duration_i >> 1;
      half_m1_s  = {DIV_W{1'b0}};
      full_m1_s  = {DIV_W{1'b0}};
      if (half_s != {DIV_W{1'b0}}) begin
         half_m1_s = half_s - DIV_W'(1);
      end else begin
         half_m1_s = {DIV_W{1'b0}};
      end
      if (bit_duration_i != {DIV_W{1'b0}}) begin
         full_m1_s = bit_duration_i - DIV_W'(1);
      end else begin
         full_m1_s = {DIV_W{1'b0}};
      end
      // >= rather than == so a mid-frame shrink of the duration never misses its compare
      half_hit_s = (cnt_r >= half_m1_s);
      full_hit_s = (cnt_r >= full_m1_s);
   end

   // Receiver FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_s) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic plus the per-cycle sample/push/error strobes.
   always_comb begin
      state_s      = state_r;
      sample_bit_s = 1'b0;
      push_s       = 1'b0;
      frame_set_s  = 1'b0;
      if (!rx_en_i) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!rxs_r) begin
                  state_s = ST_START;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_START: begin
               if (half_hit_s) begin
                  if (!rxs_r) begin
                     state_s = ST_DATA;
                  end else begin
                     state_s = ST_IDLE;
                  end
               end else begin
                  state_s = ST_START;
               end
            end
            ST_DATA: begin
               if (full_hit_s) begin
                  sample_bit_s = 1'b1;
                  if (bit_idx_r == IDX_W'(DATA_W - 1)) begin
                     state_s = ST_STOP;
                  end else begin
                     state_s = ST_DATA;
                  end
               end else begin
                  state_s = ST_DATA;
               end
            end
            ST_STOP: begin
               if (full_hit_s) begin
                  if (rxs_r) begin
                     push_s  = 1'b1;
                     state_s = ST_IDLE;
                  end else begin
                     frame_set_s = 1'b1;
                     state_s     = ST_BRK;
                  end
               end else begin
                  state_s = ST_STOP;
               end
            end
            ST_BRK: begin
               if (rxs_r) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s = ST_BRK;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
      // The bit timer restarts on every state entry and after each data sample
      cnt_clr_s = (state_s != state_r) || sample_bit_s ||
                  (state_r == ST_IDLE) || (state_r == ST_BRK);
   end

   // Bit timer, bit index and LSB-first shift register.
   always_ff @(posedge clk_i) begin
      if (rst_s) begin
         cnt_r     <= {DIV_W{1'b0}};
         bit_idx_r <= {IDX_W{1'b0}};
         shift_r   <= {DATA_W{1'b0}};
      end else begin
         if (cnt_clr_s) begin
            cnt_r <= {DIV_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + DIV_W'(1);
         end
         if (state_r != ST_DATA) begin
            bit_idx_r <= {IDX_W{1'b0}};
         end else if (sample_bit_s) begin
            bit_idx_r <= bit_idx_r + IDX_W'(1);
         end else begin
            bit_idx_r <= bit_idx_r;
         end
         if (sample_bit_s) begin
            shift_r <= {rxs_r, shift_r[DATA_W-1:1]};
         end else begin
            shift_r <= shift_r;
         end
      end
   end

   // FIFO control: a push is accepted when not full or when a pop frees the slot.
   always_comb begin
      pop_s     = valid_r && ready_i;
      full_s    = (count_r == CNT_W'(DEPTH));
      wr_en_s   = push_s && (!full_s || pop_s);
      ovr_set_s = push_s && full_s && !pop_s;
      case ({wr_en_s, pop_s})
         2'b10:   count_s = count_r + CNT_W'(1);
         2'b01:   count_s = count_r - CNT_W'(1);
         default: count_s = count_r;
      endcase
   end

   // FIFO storage, pointers, occupancy and the registered valid/RTS outputs.
   always_ff @(posedge clk_i) begin
      if (rst_s) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
         wr_ptr_r <= {FIFO_AW{1'b0}};
         rd_ptr_r <= {FIFO_AW{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         valid_r  <= 1'b0;
         rts_r    <= 1'b0;
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= shift_r;
            wr_ptr_r        <= wr_ptr_r + FIFO_AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         count_r <= count_s;
         valid_r <= (count_s != {CNT_W{1'b0}});
         // Keep one spare slot so a frame already on the wire still fits
         rts_r   <= rx_en_i && ((CNT_W'(DEPTH) - count_s) >= CNT_W'(2));
      end
   end

   // Sticky error flags; a set event beats a simultaneous clear.
   always_ff @(posedge clk_i) begin
      if (rst_s) begin
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         if (frame_set_s) begin
            frame_err_r <= 1'b1;
         end else if (err_clr_i) begin
            frame_err_r <= 1'b0;
         end else begin
            frame_err_r <= frame_err_r;
         end
         if (ovr_set_s) begin
            overrun_r <= 1'b1;
         end else if (err_clr_i) begin
            overrun_r <= 1'b0;
         end else begin
            overrun_r <= overrun_r;
         end
      end
   end

   assign data_o      = mem_r[rd_ptr_r];
   assign valid_o     = valid_r;
   assign rts_o       = rts_r;
   assign frame_err_o = frame_err_r;
   assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Testbench for uart_rx_engine: scenario tasks plus a pop-side scoreboard.
module tb_uart_rx_engine;

   localparam int BD = 16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        rst_soft_i;
   logic        rx_en_i;
   logic [15:0] bit_duration_i;
   logic        rxd_i;
   logic        rts_o;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i;
   logic        frame_err_o;
   logic        overrun_o;
   logic        err_clr_i;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   uart_rx_engine dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .rst_soft_i     (rst_soft_i),
      .rx_en_i        (rx_en_i),
      .bit_duration_i (bit_duration_i),
      .rxd_i          (rxd_i),
      .rts_o          (rts_o),
      .data_o         (data_o),
      .valid_o        (valid_o),
      .ready_i        (ready_i),
      .frame_err_o    (frame_err_o),
      .overrun_o      (overrun_o),
      .err_clr_i      (err_clr_i)
   );

   always #5 clk_i = ~clk_i;

   // Scoreboard: every accepted word must match the oldest expected word.
   always @(negedge clk_i) begin
      logic [7:0] e;
      if (valid_o && ready_i && !rst_i && !rst_soft_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected got=%h exp=none", data_o);
         end else begin
            e = exp_q.pop_front();
            if (data_o !== e) begin
               errors++;
               $display("FAIL pop_data got=%h exp=%h", data_o, e);
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic drive_bits(input logic [7:0] d, input int nbits);
      @(posedge clk_i);
      #1 rxd_i = 1'b0;
      repeat (BD) @(posedge clk_i);
      for (int i = 0; i < nbits; i++) begin
         #1 rxd_i = d[i];
         repeat (BD) @(posedge clk_i);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      drive_bits(d, 8);
      #1 rxd_i = stop_b;
      repeat (BD) @(posedge clk_i);
   endtask

   task automatic check1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   task automatic clear_errors();
      @(posedge clk_i);
      #1 err_clr_i = 1'b1;
      @(posedge clk_i);
      #1 err_clr_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; rst_soft_i = 1'b0; rx_en_i = 1'b1; bit_duration_i = 16'd16;
      rxd_i = 1'b1; ready_i = 1'b1; err_clr_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if ({valid_o, rts_o, frame_err_o, overrun_o, data_o} !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs got=%b%b%b%b_%h exp=0000_00", valid_o, rts_o, frame_err_o, overrun_o, data_o);
      end
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check1("rts_after_reset", rts_o, 1'b1);
   endtask

   task automatic test_basic();
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 1'b1);
         begin
            @(posedge clk_i);
            repeat (154) @(posedge clk_i);
            @(negedge clk_i);
            check1("basic_valid_before", valid_o, 1'b0);
            @(posedge clk_i);
            @(negedge clk_i);
            check1("basic_valid_at", valid_o, 1'b1);
            checks++;
            if (data_o !== 8'hA5) begin
               errors++;
               $display("FAIL basic_data got=%h exp=a5", data_o);
            end
            @(posedge clk_i);
            @(negedge clk_i);
            check1("basic_valid_after", valid_o, 1'b0);
         end
      join
      @(negedge clk_i);
      check1("basic_frame_err", frame_err_o, 1'b0);
      check1("basic_overrun", overrun_o, 1'b0);
      check1("basic_rts", rts_o, 1'b1);
   endtask

   task automatic test_glitch();
      @(posedge clk_i);
      #1 rxd_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1 rxd_i = 1'b1;
      repeat (40) @(posedge clk_i);
      @(negedge clk_i);
      check1("glitch_valid", valid_o, 1'b0);
      check1("glitch_frame_err", frame_err_o, 1'b0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      #1 rxd_i = 1'b1;
      repeat (4) @(posedge clk_i);
      @(negedge clk_i);
      check1("glitch_after_ferr", frame_err_o, 1'b0);
   endtask

   task automatic test_framing();
      send_frame(8'h3C, 1'b0);
      repeat (200) @(posedge clk_i);
      @(negedge clk_i);
      check1("frame_err_set", frame_err_o, 1'b1);
      check1("frame_no_push", valid_o, 1'b0);
      @(posedge clk_i);
      #1 rxd_i = 1'b1;
      repeat (5) @(posedge clk_i);
      clear_errors();
      @(negedge clk_i);
      check1("frame_err_clr", frame_err_o, 1'b0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      #1 rxd_i = 1'b1;
      repeat (4) @(posedge clk_i);
      @(negedge clk_i);
      check1("frame_err_stays_clr", frame_err_o, 1'b0);
   endtask

   task automatic test_back_to_back();
      ready_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) exp_q.push_back(8'(k));
         send_frame(8'(k), 1'b1);
         @(negedge clk_i);
         check1($sformatf("b2b_rts_w%0d", k), rts_o, (k < 3));
         check1($sformatf("b2b_ovr_w%0d", k), overrun_o, (k == 5));
      end
      checks++;
      if (data_o !== 8'h01 || valid_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_head got=%h/%b exp=01/1", data_o, valid_o);
      end
      @(posedge clk_i);
      #1 ready_i = 1'b1;
      repeat (8) @(posedge clk_i);
      @(negedge clk_i);
      check1("b2b_drained", valid_o, 1'b0);
      check1("b2b_rts_back", rts_o, 1'b1);
      clear_errors();
      @(negedge clk_i);
      check1("b2b_ovr_clr", overrun_o, 1'b0);
   endtask

   task automatic test_reset_midframe();
      ready_i = 1'b0;
      send_frame(8'h77, 1'b1);
      @(negedge clk_i);
      check1("rst_pre_valid", valid_o, 1'b1);
      drive_bits(8'h5A, 3);
      #1 rst_i = 1'b1;
      rxd_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if ({valid_o, rts_o, frame_err_o, overrun_o, data_o} !== 12'h000) begin
         errors++;
         $display("FAIL rst_mid_outputs got=%b%b%b%b_%h exp=0000_00", valid_o, rts_o, frame_err_o, overrun_o, data_o);
      end
      rst_i = 1'b0;
      ready_i = 1'b1;
      repeat (30) @(posedge clk_i);
      @(negedge clk_i);
      check1("rst_mid_empty", valid_o, 1'b0);
      exp_q.push_back(8'h99);
      send_frame(8'h99, 1'b1);
      repeat (4) @(posedge clk_i);
   endtask

   task automatic test_soft_reset();
      ready_i = 1'b0;
      send_frame(8'h42, 1'b1);
      @(negedge clk_i);
      check1("srst_pre_valid", valid_o, 1'b1);
      @(posedge clk_i);
      #1 rst_soft_i = 1'b1;
      @(posedge clk_i);
      #1 rst_soft_i = 1'b0;
      @(negedge clk_i);
      check1("srst_valid", valid_o, 1'b0);
      ready_i = 1'b1;
      repeat (4) @(posedge clk_i);
   endtask

   task automatic test_rx_disable();
      ready_i = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      exp_q.push_back(8'h22);
      send_frame(8'h22, 1'b1);
      drive_bits(8'h33, 3);
      #1 rx_en_i = 1'b0;
      rxd_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      check1("dis_rts", rts_o, 1'b0);
      @(posedge clk_i);
      #1 rx_en_i = 1'b1;
      repeat (BD * 12) @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if (data_o !== 8'h11 || valid_o !== 1'b1) begin
         errors++;
         $display("FAIL dis_head got=%h/%b exp=11/1", data_o, valid_o);
      end
      check1("dis_rts_back", rts_o, 1'b1);
      check1("dis_ovr", overrun_o, 1'b0);
      check1("dis_ferr", frame_err_o, 1'b0);
      @(posedge clk_i);
      #1 ready_i = 1'b1;
      repeat (6) @(posedge clk_i);
      @(negedge clk_i);
      check1("dis_drained", valid_o, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_back_to_back();
      test_reset_midframe();
      test_soft_reset();
      test_rx_disable();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
